// File: rtl/k_param_pkg.sv
// Shared widths, fixed-point slice bounds and FSM encoding for the k-parameter loader.
// The loader, its converter and any neuron datapath reading the table import this package.
package k_param_pkg;
    localparam int DWIDTH     = 16;
    localparam int AWIDTH     = 4;
    localparam int DWIDTH_TMP = 32;
    localparam int DEPTH      = 2 ** AWIDTH;

    localparam logic [DWIDTH-1:0] SAT_MAX = 16'hFFFF;

    // 8.24 -> 6.10 keeps integer bits [29:24] and the top ten fraction bits.
    localparam int FRAC_HI = 29;
    localparam int FRAC_LO = 14;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // A count of 0, or anything above the table depth, means "fill the whole table".
    function automatic logic [AWIDTH:0] eff_count(input logic [AWIDTH:0] c);
        if (c == '0 || c > (AWIDTH+1)'(DEPTH))
            return (AWIDTH+1)'(DEPTH);
        return c;
    endfunction
endpackage

// File: rtl/k_param_conv.sv
// Combinational 8.24 -> 6.10 narrowing: truncates the low fraction bits and
// saturates to all-ones when any integer bit above the 6.10 range is set.
module k_param_conv
    import k_param_pkg::*;
(
    input  logic [DWIDTH_TMP-1:0] din,
    output logic [DWIDTH-1:0]     dout,
    output logic                  sat
);
    assign sat  = |din[DWIDTH_TMP-1:FRAC_HI+1];
    assign dout = sat ? SAT_MAX : din[FRAC_HI:FRAC_LO];
endmodule

// File: rtl/k_param_loader.sv
// Run-time writable k table: a counted burst of 8.24 words is narrowed to 6.10
// and written sequentially; neuron datapaths read it through a registered port.
module k_param_loader
    import k_param_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [AWIDTH:0]       count,
    input  logic                  wr_valid,
    input  logic [DWIDTH_TMP-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  sat_flag,
    input  logic                  rd_en,
    input  logic [AWIDTH-1:0]     rd_addr,
    output logic [DWIDTH-1:0]     rd_data,
    output logic [1:0]            state_dbg
);
    localparam logic [AWIDTH-1:0] PTR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [AWIDTH:0]   REM_ONE = {{AWIDTH{1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH:0]   remaining;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] conv_data;
    logic              conv_sat;
    logic              accept;

    k_param_conv u_conv (
        .din  (wr_data),
        .dout (conv_data),
        .sat  (conv_sat)
    );

    // Handshake: a word transfers on every rising edge where wr_valid && wr_ready;
    // wr_ready depends only on state, so the producer may hold wr_valid low indefinitely.
    assign wr_ready  = (state == LOAD);
    assign accept    = wr_valid && wr_ready;
    assign busy      = (state == LOAD) || (state == DONE);
    assign done      = (state == DONE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            remaining <= '0;
            sat_flag  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        wr_ptr    <= '0;
                        remaining <= eff_count(count);
                        sat_flag  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        wr_ptr    <= wr_ptr + PTR_ONE;
                        remaining <= remaining - REM_ONE;
                        if (conv_sat)
                            sat_flag <= 1'b1;
                        if (remaining == REM_ONE)
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Flop array with asynchronous clear so a reset leaves the table all-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (accept) begin
            mem[wr_ptr] <= conv_data;
        end
    end

    // Reads sample the pre-edge contents, so a colliding write is seen one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
        else
            rd_data <= '0;
    end
endmodule
